// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between three writeback
// sources: 0 = ALU result, 1 = load data, 2 = link/PC value. Each source owns
// a one-entry holding buffer. The arbiter picks one full buffer per cycle,
// drives the select of the external 32-bit 3:1 writeback mux and produces the
// register-file write enable and address.
//
// Parameters:
//   DATA_W   width of each buffered write value (matches mux inputs)
//   ADDR_W   register-file address width
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   rst            synchronous, active-high reset
//   srcN_valid     source N presents a write request          (N = 0,1,2)
//   srcN_addr      destination register for source N
//   srcN_data      write value for source N
//   srcN_ready     buffer N is empty; request accepted on valid & ready
//   bufN_data      buffered value of source N, wired to mux input N
//   mux_sel        writeback mux select; 2'b11 when idle (mux outputs 0)
//   rf_we          register-file write enable
//   rf_waddr       register-file write address (0 when idle)
//   busy           any buffer full or a write in progress
//
// Handshake: a source transfers on every rising edge where srcN_valid and
// srcN_ready are both high. srcN_ready is simply "buffer empty", so a full
// buffer can never be reloaded in the same cycle it is being freed.
//
// Configuration macro:
//   WB_ARB_FIXED_PRIO_EN  defined   -> fixed priority 0 > 1 > 2, no
//                                      round-robin pointer.
//                         undefined -> round-robin (default).
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              src0_valid,
    input  logic [ADDR_W-1:0] src0_addr,
    input  logic [DATA_W-1:0] src0_data,
    output logic              src0_ready,

    input  logic              src1_valid,
    input  logic [ADDR_W-1:0] src1_addr,
    input  logic [DATA_W-1:0] src1_data,
    output logic              src1_ready,

    input  logic              src2_valid,
    input  logic [ADDR_W-1:0] src2_addr,
    input  logic [DATA_W-1:0] src2_data,
    output logic              src2_ready,

    output logic [DATA_W-1:0] buf0_data,
    output logic [DATA_W-1:0] buf1_data,
    output logic [DATA_W-1:0] buf2_data,

    output logic [1:0]        mux_sel,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic              busy
);

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // Next source index in the ring 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] ring_next(input logic [1:0] idx);
        logic [1:0] r;
        case (idx)
            2'd0:    r = 2'd1;
            2'd1:    r = 2'd2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Bit select of a 3-bit vector by a 2-bit index; index 3 reads as 0.
    function automatic logic bit_at(input logic [2:0] v, input logic [1:0] idx);
        logic r;
        case (idx)
            2'd0:    r = v[0];
            2'd1:    r = v[1];
            2'd2:    r = v[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Input gathering
    // -----------------------------------------------------------------------
    logic [2:0]        src_valid;
    logic [ADDR_W-1:0] src_addr [3];
    logic [DATA_W-1:0] src_data [3];

    assign src_valid   = {src2_valid, src1_valid, src0_valid};
    assign src_addr[0] = src0_addr;
    assign src_addr[1] = src1_addr;
    assign src_addr[2] = src2_addr;
    assign src_data[0] = src0_data;
    assign src_data[1] = src1_data;
    assign src_data[2] = src2_data;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [2:0]        full_q;
    logic [2:0]        full_d;
    logic [ADDR_W-1:0] addr_q [3];
    logic [DATA_W-1:0] data_q [3];

    logic              g_valid_q;
    logic [1:0]        g_idx_q;

`ifdef WB_ARB_FIXED_PRIO_EN
`else
    logic [1:0]        last_q;
`endif

    // -----------------------------------------------------------------------
    // Accept / free bookkeeping
    // -----------------------------------------------------------------------
    logic [2:0] accept;
    logic [2:0] gnt_mask;   // one-hot of the buffer being written this cycle
    logic [2:0] cand;

    always_comb begin
        accept   = src_valid & ~full_q;
        gnt_mask = g_valid_q ? (3'b001 << g_idx_q) : 3'b000;

        // The buffer currently on the write port is freed at the next edge,
        // so it must not win again.
        cand     = full_q & ~gnt_mask;

        // Accept and free never hit the same bit: accept needs the buffer
        // empty, free needs it full.
        full_d   = (full_q | accept) & ~gnt_mask;
    end

    // -----------------------------------------------------------------------
    // Winner selection
    // -----------------------------------------------------------------------
    logic       win_valid;
    logic [1:0] win_idx;

`ifdef WB_ARB_FIXED_PRIO_EN
    always_comb begin
        win_valid = |cand;
        win_idx   = 2'd0;
        if (cand[0]) begin
            win_idx = 2'd0;
        end else if (cand[1]) begin
            win_idx = 2'd1;
        end else if (cand[2]) begin
            win_idx = 2'd2;
        end
    end
`else
    logic [1:0] prio1;
    logic [1:0] prio2;

    // Search order: last+1, last+2, then last itself (last+3 mod 3).
    always_comb begin
        prio1     = ring_next(last_q);
        prio2     = ring_next(prio1);
        win_valid = |cand;
        win_idx   = 2'd0;
        if (bit_at(cand, prio1)) begin
            win_idx = prio1;
        end else if (bit_at(cand, prio2)) begin
            win_idx = prio2;
        end else if (bit_at(cand, last_q)) begin
            win_idx = last_q;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= 3'b000;
            g_valid_q <= 1'b0;
            g_idx_q   <= 2'd0;
`ifdef WB_ARB_FIXED_PRIO_EN
`else
            // Source 0 is first in line after reset.
            last_q    <= 2'd2;
`endif
            for (int i = 0; i < 3; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            full_q    <= full_d;
            g_valid_q <= win_valid;
            if (win_valid) begin
                g_idx_q <= win_idx;
`ifdef WB_ARB_FIXED_PRIO_EN
`else
                last_q  <= win_idx;
`endif
            end
            // Buffer contents are only written on accept, so they stay
            // stable through the whole write cycle.
            for (int i = 0; i < 3; i++) begin
                if (accept[i]) begin
                    addr_q[i] <= src_addr[i];
                    data_q[i] <= src_data[i];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] waddr_sel;

    always_comb begin
        waddr_sel = '0;
        if (g_valid_q) begin
            case (g_idx_q)
                2'd0:    waddr_sel = addr_q[0];
                2'd1:    waddr_sel = addr_q[1];
                2'd2:    waddr_sel = addr_q[2];
                default: waddr_sel = '0;
            endcase
        end
    end

    assign src0_ready = ~full_q[0];
    assign src1_ready = ~full_q[1];
    assign src2_ready = ~full_q[2];

    assign buf0_data  = data_q[0];
    assign buf1_data  = data_q[1];
    assign buf2_data  = data_q[2];

    assign mux_sel    = g_valid_q ? g_idx_q : 2'b11;
    assign rf_we      = g_valid_q;
    assign rf_waddr   = waddr_sel;
    assign busy       = (|full_q) | g_valid_q;

endmodule
